// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle MIPS-subset core on one handshaked memory port; define MCDP_JUMP_EN to enable j
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter bit          INIT_REGS = 1'b1,
  parameter int          CNT_W     = 16
) (
  input  logic             clock,
  input  logic             clear,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  input  logic [4:0]       dbg_sel,
  output logic [31:0]      dbg_data,
  output logic [31:0]      pc,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9,
    ADDIWB = 4'd10, JUMP = 4'd11, HALT = 4'd15
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
`ifdef MCDP_JUMP_EN
  localparam logic [5:0] OP_J = 6'h02;
`endif
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];
  logic             reg_we, retire, funct_ok;
  logic [4:0]       reg_wa, rs, rt, rd;
  logic [5:0]       op, funct;
  logic [31:0]      reg_wd, alu_res, imm_sx;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sx   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign funct_ok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};

  assign pc       = pc_q;
  assign state    = state_q;
  assign halted   = state_q == HALT;
  assign retired  = retired_q;
  assign dbg_data = dbg_sel == 5'd0 ? 32'd0 : regs_q[dbg_sel];

  function automatic logic [31:0] init_val(input int i);
    if (!INIT_REGS) return 32'd0;
    return i == 1 ? 32'd1 : i == 2 ? 32'd2 : i == 3 ? DATA_BASE : 32'd0;
  endfunction

  // state register; clear drops any in-flight transfer back to FETCH
  always_ff @(posedge clock or posedge clear)
    if (clear) state_q <= FETCH;
    else       state_q <= state_d;

  // next-state: memory states wait on mem_ready, decode dispatches on opcode
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        state_d = HALT;
        if (op == OP_LW || op == OP_SW) state_d = MEMADR;
        else if (op == OP_R)            state_d = EXEC;
        else if (op == OP_BEQ)          state_d = BRANCH;
        else if (op == OP_ADDI)         state_d = ADDIEX;
`ifdef MCDP_JUMP_EN
        else if (op == OP_J)            state_d = JUMP;
`endif
      end
      MEMADR: state_d = op == OP_LW ? MEMRD : MEMWR;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = funct_ok ? ALUWB : HALT;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
      default: state_d = HALT;
    endcase
  end

  // outputs: memory requests are masked while clear is high even though state reads FETCH
  always_comb begin
    mem_read  = !clear && (state_q == FETCH || state_q == MEMRD);
    mem_write = !clear && state_q == MEMWR;
    mem_addr  = (state_q == MEMRD || state_q == MEMWR) ? alu_q : pc_q;
    mem_wdata = b_q;
    reg_we    = state_q inside {MEMWB, ALUWB, ADDIWB};
    reg_wa    = state_q == ALUWB ? rd : rt;
    reg_wd    = state_q == MEMWB ? mdr_q : alu_q;
    retire    = state_q inside {MEMWB, ALUWB, ADDIWB, BRANCH, JUMP} || (state_q == MEMWR && mem_ready);
  end

  // R-type ALU; unlisted functs never reach ALUWB so their result is irrelevant
  always_comb
    alu_res = funct == F_ADD ? a_q + b_q :
              funct == F_SUB ? a_q - b_q :
              funct == F_AND ? a_q & b_q :
              funct == F_OR  ? a_q | b_q :
              {31'd0, $signed(a_q) < $signed(b_q)};

  // datapath register updates per state
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    case (state_q)
      FETCH: if (mem_ready) begin
        ir_d = mem_rdata;
        pc_d = pc_q + 32'd4;
      end
      DECODE: begin
        a_d   = regs_q[rs];
        b_d   = regs_q[rt];
        alu_d = pc_q + (imm_sx << 2);
      end
      MEMADR, ADDIEX: alu_d = a_q + imm_sx;
      MEMRD:  if (mem_ready) mdr_d = mem_rdata;
      EXEC:   alu_d = alu_res;
      BRANCH: if (a_q == b_q) pc_d = alu_q;
      JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: ;
    endcase
  end

  // register file write port; $0 stays zero
  always_comb begin
    regs_d = regs_q;
    if (reg_we && reg_wa != 5'd0) regs_d[reg_wa] = reg_wd;
  end

  // datapath and register file storage
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      retired_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= init_val(i);
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: scoreboard bench for multicycle_datapath
module tb_multicycle_datapath;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] DB  = 32'h1001_0000;
  localparam logic [31:0] ILL = 32'hFC00_0000;
  localparam logic [5:0]  F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  logic        clock = 1'b0, clear = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_data, pc;
  logic        mem_read, mem_write, mem_ready, halted;
  logic [4:0]  dbg_sel;
  logic [3:0]  state;
  logic [15:0] retired;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];

  typedef struct {
    string       tag;
    int          kind;
    logic [4:0]  r;
    logic [31:0] a;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;

  multicycle_datapath dut (
    .clock(clock), .clear(clear),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .pc(pc), .state(state), .halted(halted), .retired(retired)
  );

  always #5 clock = ~clock;

  always_comb mem_rdata = mem_addr[31:28] == 4'h0 ? imem[mem_addr[7:2]] : dmem[mem_addr[5:2]];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] f);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [4:0] r, input logic [31:0] a, input logic [31:0] v);
    sb.push_back('{tag, kind, r, a, v});
  endtask

  task automatic load_clear();
    for (int i = 0; i < 64; i++) imem[i] = ILL;
    for (int i = 0; i < 16; i++) dmem[i] = 32'd0;
    sb.delete();
  endtask

  task automatic step();
    logic wr;
    logic [3:0] wa;
    logic [31:0] wd;
    wr = mem_write && mem_ready;
    wa = mem_addr[5:2];
    wd = mem_wdata;
    @(posedge clock);
    if (wr) dmem[wa] = wd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    mem_ready = 1'b1;
    clear = 1'b1;
    #1;
    check("rst_pc", pc, RPC);
    check("rst_state", 32'(state), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_read", 32'(mem_read), 32'd0);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (e.kind == 0) begin
      dbg_sel = e.r;
      #1;
      check(e.tag, dbg_data, e.v);
    end else if (e.kind == 1) check(e.tag, dmem[e.a[5:2]], e.v);
    else check(e.tag, pc, e.v);
  endtask

  task automatic run(input int n, input int budget, input int fst, input int mst,
                     input logic [31:0] faddr, input logic [31:0] maddr, output int cyc);
    int fs, ms, got;
    logic [15:0] last;
    fs = 0; ms = 0; got = 0; cyc = 0;
    last = retired;
    while (got < n && cyc < budget) begin
      if (state == 4'd0 && fs < fst) begin
        mem_ready = 1'b0;
        fs++;
        #0;
        check("stall_fetch_read", 32'(mem_read), 32'd1);
        check("stall_fetch_addr", mem_addr, faddr);
      end else if (state == 4'd3 && ms < mst) begin
        mem_ready = 1'b0;
        ms++;
        #0;
        check("stall_mem_read", 32'(mem_read), 32'd1);
        check("stall_mem_addr", mem_addr, maddr);
      end else mem_ready = 1'b1;
      step();
      cyc++;
      if (retired != last) begin
        last = retired;
        got++;
        score();
      end
    end
    if (got < n) check("timeout_retire", got, n);
    mem_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    dbg_sel = 5'd0;
    mem_ready = 1'b1;

    load_clear();
    imem[0] = rtype(1, 2, 3, F_ADD);
    imem[1] = rtype(1, 2, 3, F_SUB);
    imem[2] = rtype(1, 2, 3, F_AND);
    imem[3] = rtype(1, 2, 3, F_OR);
    imem[4] = rtype(1, 2, 3, F_SLT);
    imem[5] = rtype(2, 1, 3, F_SLT);
    push("add", 0, 3, 0, 32'd3);
    push("sub", 0, 3, 0, 32'hFFFF_FFFF);
    push("and", 0, 3, 0, 32'd0);
    push("or", 0, 3, 0, 32'd3);
    push("slt_lt", 0, 3, 0, 32'd1);
    push("slt_ge", 0, 3, 0, 32'd0);
    do_reset();
    dbg_sel = 5'd1; #1; check("init_r1", dbg_data, 32'd1);
    dbg_sel = 5'd3; #1; check("init_r3", dbg_data, DB);
    run(6, 40, 0, 0, 32'd0, 32'd0, cyc);
    check("rtype_cycles", cyc, 32'd24);
    check("rtype_retired", 32'(retired), 32'd6);

    load_clear();
    imem[0] = itype(6'h23, 3, 4, 16'd0);
    imem[1] = itype(6'h23, 3, 4, 16'd4);
    imem[2] = itype(6'h2B, 3, 4, 16'd8);
    imem[3] = itype(6'h08, 1, 5, 16'hFFFD);
    imem[4] = itype(6'h08, 1, 0, 16'd5);
    dmem[0] = 32'd100;
    dmem[1] = 32'd200;
    push("lw0", 0, 4, 0, 32'd100);
    push("lw4", 0, 4, 0, 32'd200);
    push("sw8", 1, 0, DB + 32'd8, 32'd200);
    push("addi_neg", 0, 5, 0, 32'hFFFF_FFFE);
    push("addi_r0", 0, 0, 0, 32'd0);
    do_reset();
    run(5, 60, 0, 0, 32'd0, 32'd0, cyc);
    check("ldst_cycles", cyc, 32'd22);

    load_clear();
    imem[0] = itype(6'h23, 3, 4, 16'd4);
    dmem[1] = 32'h0000_BEEF;
    push("lw_stall", 0, 4, 0, 32'h0000_BEEF);
    do_reset();
    run(1, 40, 3, 3, RPC, DB + 32'd4, cyc);
    check("stall_cycles", cyc, 32'd11);

    load_clear();
    imem[0] = itype(6'h04, 1, 2, 16'd5);
    imem[1] = itype(6'h04, 0, 0, 16'hFFFF);
    push("beq_nt_pc", 2, 0, 0, RPC + 32'd4);
    push("beq_loop1", 2, 0, 0, RPC + 32'd4);
    push("beq_loop2", 2, 0, 0, RPC + 32'd4);
    push("beq_loop3", 2, 0, 0, RPC + 32'd4);
    do_reset();
    run(4, 40, 0, 0, 32'd0, 32'd0, cyc);
    check("beq_cycles", cyc, 32'd12);

    load_clear();
    do_reset();
    step();
    check("ill_decode", 32'(state), 32'd1);
    step();
    check("ill_state", 32'(state), 32'd15);
    check("ill_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ill_pc", pc, RPC + 32'd4);
      check("ill_read", 32'(mem_read), 32'd0);
      check("ill_write", 32'(mem_write), 32'd0);
      check("ill_hold", 32'(state), 32'd15);
    end
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("ill_clr_pc", pc, RPC);
    check("ill_clr_halted", 32'(halted), 32'd0);
    @(negedge clock);
    clear = 1'b0;

    load_clear();
    imem[0] = rtype(1, 2, 3, 6'h3F);
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check("badfunct_state", 32'(state), 32'd15);
    dbg_sel = 5'd3; #1;
    check("badfunct_r3", dbg_data, DB);

    load_clear();
    imem[0] = {6'h02, 26'h010_0002};
`ifdef MCDP_JUMP_EN
    push("j_pc", 2, 0, 0, RPC + 32'd8);
    do_reset();
    run(1, 10, 0, 0, 32'd0, 32'd0, cyc);
    check("j_cycles", cyc, 32'd3);
`else
    do_reset();
    step();
    step();
    check("j_illegal", 32'(state), 32'd15);
`endif

    load_clear();
    imem[0] = itype(6'h2B, 3, 1, 16'd8);
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check("sw_state", 32'(state), 32'd5);
    check("sw_write", 32'(mem_write), 32'd1);
    check("sw_addr", mem_addr, DB + 32'd8);
    check("sw_wdata", mem_wdata, 32'd1);
    mem_ready = 1'b0;
    step();
    check("sw_wait", 32'(state), 32'd5);
    check("sw_nowrite_wait", dmem[2], 32'd0);
    #2;
    clear = 1'b1;
    #1;
    check("abort_write", 32'(mem_write), 32'd0);
    check("abort_read", 32'(mem_read), 32'd0);
    check("abort_pc", pc, RPC);
    check("abort_addr", mem_addr, RPC);
    check("abort_state", 32'(state), 32'd0);
    check("abort_retired", 32'(retired), 32'd0);
    mem_ready = 1'b1;
    step();
    check("abort_mem", dmem[2], 32'd0);
    @(negedge clock);
    clear = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
